// File: rtl/float_to_fixed_pipe_pkg.sv
// float_fixed_pkg: shared definitions for the float-to-fixed converter.
//   RND_TRUNC / RND_RNE : rounding mode encodings carried with each operand.
//   fx_class_t          : operand classification decided in the unpack stage.
//   fx_flags_t          : status flag bundle delivered with every result.
//   exp_bias()          : IEEE-754 exponent bias for a given exponent width.
package float_fixed_pkg;

    localparam logic RND_TRUNC = 1'b0;  // truncate toward zero
    localparam logic RND_RNE   = 1'b1;  // round to nearest, ties to even

    typedef enum logic [1:0] {
        CLS_NORM,   // normal number, goes through alignment
        CLS_ZERO,   // zero or denormal, result forced to 0
        CLS_INF,    // infinity, saturates per sign
        CLS_NAN     // not-a-number
    } fx_class_t;

    typedef struct packed {
        logic ovf;
        logic inv;
        logic inexact;
    } fx_flags_t;

    function automatic int unsigned exp_bias(input int unsigned ew);
        return (32'd1 << (ew - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/float_to_fixed_pipe_if.sv
// float_to_fixed_pipe_if: operand and result channels of the converter.
//   in_valid/in_ready/float_op/rnd_mode   : operand channel (master -> slave)
//   out_valid/out_ready/fixed/ovf/inv/inexact : result channel (slave -> master)
// Handshake: a beat transfers on a rising edge where valid and ready are both 1.
// A source holding valid keeps its payload stable until the transfer; ready may
// depend combinationally on the consumer side, valid never depends on ready.
interface float_to_fixed_pipe_if #(
    parameter int EW  = 8,
    parameter int MW  = 23,
    parameter int FXW = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [EW+MW:0]    float_op;
    logic              rnd_mode;
    logic              out_valid;
    logic              out_ready;
    logic [FXW-1:0]    fixed;
    logic              ovf;
    logic              inv;
    logic              inexact;

    modport master (
        output in_valid, float_op, rnd_mode, out_ready,
        input  in_ready, out_valid, fixed, ovf, inv, inexact
    );

    modport slave (
        input  in_valid, float_op, rnd_mode, out_ready,
        output in_ready, out_valid, fixed, ovf, inv, inexact
    );
endinterface

// File: rtl/fx_align_shifter.sv
// fx_align_shifter: moves the integer mantissa {1,m} by a signed amount.
//   mant      : MW+1 bit integer mantissa
//   shift     : signed shift, >= 0 shifts left, < 0 shifts right
//   mag       : low FXW bits of the aligned integer magnitude
//   big       : aligned magnitude does not fit in FXW bits
//   guard     : first bit below the result LSB (right shifts only)
//   round_bit : second bit below the result LSB
//   sticky    : OR of every lower discarded bit
module fx_align_shifter #(
    parameter int MW  = 23,
    parameter int FXW = 32,
    parameter int SW  = 18
) (
    input  logic [MW:0]           mant,
    input  logic signed [SW-1:0]  shift,
    output logic [FXW-1:0]        mag,
    output logic                  big,
    output logic                  guard,
    output logic                  round_bit,
    output logic                  sticky
);
    localparam int LW   = MW + FXW + 1;  // wide enough for either direction
    localparam int RW   = 2 * MW + 4;    // mantissa plus MW+3 fraction slots
    localparam int RMAX = MW + 3;        // beyond this everything lands in sticky

    logic [LW-1:0] wide;
    logic [RW-1:0] rvec;
    logic [SW-1:0] amt;

    always_comb begin
        wide      = '0;
        rvec      = '0;
        amt       = '0;
        guard     = 1'b0;
        round_bit = 1'b0;
        sticky    = 1'b0;
        if (!shift[SW-1]) begin
            // Clamping at FXW keeps the leading 1 above bit FXW-1, so overflow
            // is still reported instead of the value wrapping.
            amt  = ($unsigned(shift) > SW'(FXW)) ? SW'(FXW) : $unsigned(shift);
            wide = LW'(mant) << amt;
        end else begin
            amt  = $unsigned(-shift);
            if (amt > SW'(RMAX)) begin
                amt = SW'(RMAX);
            end
            rvec      = {mant, {(MW + 3){1'b0}}} >> amt;
            wide      = LW'(rvec[RW-1:MW+3]);
            guard     = rvec[MW+2];
            round_bit = rvec[MW+1];
            sticky    = |rvec[MW:0];
        end
        mag = wide[FXW-1:0];
        big = |wide[LW-1:FXW];
    end
endmodule

// File: rtl/float_to_fixed_pipe.sv
// float_to_fixed_pipe: 3-stage IEEE-754 to two's complement Q(FXW-FRAC-1).FRAC.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, flushes every stage
//   bus : operand channel in, result channel out (see float_to_fixed_pipe_if)
// Stage 1 classifies and computes the alignment shift, stage 2 aligns and
// rounds the magnitude, stage 3 saturates, applies the sign and registers.
module float_to_fixed_pipe
    import float_fixed_pkg::*;
#(
    parameter int EW   = 8,
    parameter int MW   = 23,
    parameter int FXW  = 32,
    parameter int FRAC = 26
) (
    input  logic                   clk,
    input  logic                   rst,
    float_to_fixed_pipe_if.slave   bus
);
    localparam int SW = EW + 10;
    localparam logic [SW-1:0] BIAS_W = SW'(exp_bias(EW));
    localparam logic [SW-1:0] FRAC_W = SW'(FRAC);
    localparam logic [SW-1:0] MW_W   = SW'(MW);

    logic adv;
    logic out_valid_q;
    logic [FXW-1:0] fixed_q;
    fx_flags_t flags_q;

    // Every stage moves together; nothing moves while the output is blocked.
    assign adv          = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.fixed     = fixed_q;
    assign bus.ovf       = flags_q.ovf;
    assign bus.inv       = flags_q.inv;
    assign bus.inexact   = flags_q.inexact;

    // ---------------- stage 1: unpack / classify ----------------
    logic              in_sign;
    logic [EW-1:0]     in_exp;
    logic [MW-1:0]     in_man;
    fx_class_t         in_cls;
    logic signed [SW-1:0] in_shift;

    assign in_sign  = bus.float_op[EW+MW];
    assign in_exp   = bus.float_op[EW+MW-1:MW];
    assign in_man   = bus.float_op[MW-1:0];
    assign in_shift = $signed(SW'(in_exp) + FRAC_W - BIAS_W - MW_W);

    always_comb begin
        in_cls = CLS_NORM;
        if (in_exp == '1) begin
            in_cls = (in_man != '0) ? CLS_NAN : CLS_INF;
        end else if (in_exp == '0) begin
            in_cls = CLS_ZERO;
        end
    end

    logic              s1_valid;
    fx_class_t         s1_cls;
    logic              s1_sign;
    logic              s1_rnd;
    logic              s1_man_nz;
    logic [MW:0]       s1_mant;
    logic signed [SW-1:0] s1_shift;

    // ---------------- stage 2: align / round ----------------
    logic [FXW-1:0] sh_mag;
    logic           sh_big;
    logic           sh_g;
    logic           sh_r;
    logic           sh_s;
    logic           rnd_inc;
    logic [FXW:0]   rnd_sum;

    fx_align_shifter #(
        .MW  (MW),
        .FXW (FXW),
        .SW  (SW)
    ) u_align (
        .mant      (s1_mant),
        .shift     (s1_shift),
        .mag       (sh_mag),
        .big       (sh_big),
        .guard     (sh_g),
        .round_bit (sh_r),
        .sticky    (sh_s)
    );

    // Round half to even on the magnitude, so both signs round identically.
    assign rnd_inc = (s1_rnd == RND_RNE) & sh_g & (sh_r | sh_s | sh_mag[0]);
    assign rnd_sum = {1'b0, sh_mag} + (FXW + 1)'(rnd_inc);

    logic           s2_valid;
    fx_class_t      s2_cls;
    logic           s2_sign;
    logic [FXW-1:0] s2_mag;
    logic           s2_big;
    logic           s2_inx;

    // ---------------- stage 3: saturate / sign ----------------
    logic [FXW-1:0] lim;
    logic [FXW-1:0] res_fixed;
    fx_flags_t      res_flags;

    // The negative limit 2^(FXW-1) and the positive limit 2^(FXW-1)-1 are also
    // the saturated two's complement results for their sign.
    assign lim = s2_sign ? {1'b1, {(FXW - 1){1'b0}}} : {1'b0, {(FXW - 1){1'b1}}};

    always_comb begin
        res_fixed = '0;
        res_flags = '0;
        case (s2_cls)
            CLS_NAN: begin
                res_flags.inv = 1'b1;
            end
            CLS_INF: begin
                res_fixed     = lim;
                res_flags.ovf = 1'b1;
            end
            CLS_ZERO: begin
                res_flags.inexact = s2_inx;
            end
            default: begin
                if (s2_big || (s2_mag > lim)) begin
                    res_fixed     = lim;
                    res_flags.ovf = 1'b1;
                end else begin
                    res_fixed         = s2_sign ? (~s2_mag + FXW'(1)) : s2_mag;
                    res_flags.inexact = s2_inx;
                end
            end
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            out_valid_q <= 1'b0;
            fixed_q     <= '0;
            flags_q     <= '0;
        end else if (adv) begin
            s1_valid    <= bus.in_valid;
            s2_valid    <= s1_valid;
            out_valid_q <= s2_valid;
            fixed_q     <= res_fixed;
            flags_q     <= res_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s1_cls    <= in_cls;
            s1_sign   <= in_sign;
            s1_rnd    <= bus.rnd_mode;
            s1_man_nz <= (in_man != '0);
            s1_mant   <= {1'b1, in_man};
            s1_shift  <= in_shift;
            s2_cls    <= s1_cls;
            s2_sign   <= s1_sign;
            s2_mag    <= rnd_sum[FXW-1:0];
            s2_big    <= sh_big | rnd_sum[FXW];
            s2_inx    <= (s1_cls == CLS_ZERO) ? s1_man_nz : (sh_g | sh_r | sh_s);
        end
    end
endmodule

// File: tb/tb_float_to_fixed_pipe.sv
// Bench for float_to_fixed_pipe: directed spec vectors with fixed expected
// values, a stalled stream, randomized traffic against an arithmetic reference
// model, a mid-flight reset and a double-precision instance.
module tb_float_to_fixed_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    float_to_fixed_pipe_if #(.EW(8),  .MW(23), .FXW(32)) bus   ();
    float_to_fixed_pipe_if #(.EW(11), .MW(52), .FXW(32)) bus_d ();

    float_to_fixed_pipe #(.EW(8), .MW(23), .FXW(32), .FRAC(26)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    float_to_fixed_pipe #(.EW(11), .MW(52), .FXW(32), .FRAC(26)) dut_d (
        .clk (clk),
        .rst (rst),
        .bus (bus_d)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit lat_chk = 1'b1;
    bit rand_done = 1'b0;
    bit hold_chk = 1'b0;
    logic [34:0] held;
    logic [34:0] exp_q[$];
    int          acc_q[$];
    logic [34:0] obs;
    logic [34:0] obs_d;

    assign obs   = {bus.fixed, bus.ovf, bus.inv, bus.inexact};
    assign obs_d = {bus_d.fixed, bus_d.ovf, bus_d.inv, bus_d.inexact};

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Reference: value = {1,m} * 2^k with k = exp - 127 - 23 + 26, rounded on
    // the magnitude via quotient and remainder, then range-checked and signed.
    function automatic logic [34:0] model(input logic [31:0] f, input bit rne);
        bit s;
        int e;
        int k;
        longint m;
        longint q;
        longint rem;
        longint half;
        longint mag;
        longint lim;
        bit inx;
        logic [31:0] fx;
        s   = f[31];
        e   = int'(f[30:23]);
        m   = longint'(f[22:0]);
        inx = 1'b0;
        if (e == 255) begin
            if (m != 0) return {32'h0, 3'b010};
            return {(s ? 32'h80000000 : 32'h7FFFFFFF), 3'b100};
        end
        if (e == 0) return {32'h0, 2'b00, (m != 0)};
        m = m + (64'sd1 <<< 23);
        k = e - 124;
        if (k >= 0) begin
            mag = (k > 32) ? 64'sh1_0000_0000 : (m <<< k);
        end else if (-k >= 40) begin
            mag = 0;
            inx = 1'b1;
        end else begin
            q    = m >>> (-k);
            rem  = m - (q <<< (-k));
            half = 64'sd1 <<< (-k - 1);
            inx  = (rem != 0);
            if (rne && ((rem > half) || ((rem == half) && q[0]))) q = q + 1;
            mag = q;
        end
        lim = s ? 64'sh8000_0000 : 64'sh7FFF_FFFF;
        if (mag > lim) return {(s ? 32'h80000000 : 32'h7FFFFFFF), 3'b100};
        fx = mag[31:0];
        if (s) fx = -fx;
        return {fx, 2'b00, inx};
    endfunction

    function automatic logic [31:0] rand_float();
        int sel;
        logic [7:0] e;
        logic [22:0] m;
        sel = $urandom_range(0, 15);
        m   = 23'($urandom);
        if (sel == 0) e = 8'hFF;
        else if (sel == 1) e = 8'h00;
        else e = 8'($urandom_range(90, 160));
        if (sel == 2) m = '0;
        return {1'($urandom_range(0, 1)), e, m};
    endfunction

    task automatic send_exp(input logic [31:0] f, input bit rne, input logic [34:0] e);
        bit acc;
        int n;
        int c;
        acc = 1'b0;
        n   = 0;
        c   = 0;
        bus.float_op = f;
        bus.rnd_mode = rne;
        bus.in_valid = 1'b1;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = bus.in_ready;
            c   = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        if (acc) begin
            exp_q.push_back(e);
            acc_q.push_back(c);
        end
        chk("send_accept", 64'(acc), 64'd1);
    endtask

    task automatic send(input logic [31:0] f, input bit rne);
        send_exp(f, rne, model(f, rne));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic send_d(input logic [63:0] f, input logic [34:0] e);
        @(negedge clk);
        chk("d_in_ready", 64'(bus_d.in_ready), 64'd1);
        bus_d.float_op = f;
        bus_d.rnd_mode = 1'b1;
        bus_d.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_d.in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k < 3) chk("d_early_valid", 64'(bus_d.out_valid), 64'd0);
        end
        chk("d_valid", 64'(bus_d.out_valid), 64'd1);
        chk("d_result", 64'(obs_d), 64'(e));
    endtask

    // Output monitor: ordering, latency, stability under stall, ready rule.
    always @(negedge clk) begin
        logic [34:0] e;
        int a;
        chk("in_ready_rule", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
        if (rst) begin
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                chk("stall_valid", 64'(bus.out_valid), 64'd1);
                chk("stall_hold", 64'(obs), 64'(held));
            end
            hold_chk = bus.out_valid && !bus.out_ready;
            held     = obs;
            if (bus.out_valid && bus.out_ready) begin
                chk("result_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    chk("result", 64'(obs), 64'(e));
                    if (lat_chk) chk("latency", 64'(cyc - a), 64'd3);
                end
            end
        end
    end

    initial begin
        bus.in_valid    = 1'b0;
        bus.float_op    = '0;
        bus.rnd_mode    = 1'b0;
        bus.out_ready   = 1'b1;
        bus_d.in_valid  = 1'b0;
        bus_d.float_op  = '0;
        bus_d.rnd_mode  = 1'b0;
        bus_d.out_ready = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_outputs", 64'(obs), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // directed vectors, back to back, exact latency
        lat_chk = 1'b1;
        send_exp(32'h3F800000, 1'b1, {32'h04000000, 3'b000});
        send_exp(32'hBF800000, 1'b1, {32'hFC000000, 3'b000});
        send_exp(32'h3FC00000, 1'b1, {32'h06000000, 3'b000});
        send_exp(32'h3FC00000, 1'b0, {32'h06000000, 3'b000});
        send_exp(32'h42000000, 1'b1, {32'h7FFFFFFF, 3'b100});
        send_exp(32'hC2000000, 1'b1, {32'h80000000, 3'b000});
        send_exp(32'h7F800000, 1'b1, {32'h7FFFFFFF, 3'b100});
        send_exp(32'hFF800000, 1'b0, {32'h80000000, 3'b100});
        send_exp(32'h4F800000, 1'b0, {32'h7FFFFFFF, 3'b100});
        send_exp(32'h41FFFFFF, 1'b1, {32'h7FFFFF80, 3'b000});
        send_exp(32'h32000000, 1'b1, {32'h00000000, 3'b001});
        send_exp(32'h32000000, 1'b0, {32'h00000000, 3'b001});
        send_exp(32'h32400000, 1'b1, {32'h00000001, 3'b001});
        send_exp(32'h32400000, 1'b0, {32'h00000000, 3'b001});
        send_exp(32'hB2400000, 1'b1, {32'hFFFFFFFF, 3'b001});
        send_exp(32'hB2400000, 1'b0, {32'h00000000, 3'b001});
        send_exp(32'h32C00000, 1'b1, {32'h00000002, 3'b001});
        send_exp(32'h32C00000, 1'b0, {32'h00000001, 3'b001});
        send_exp(32'h33200000, 1'b1, {32'h00000002, 3'b001});
        send_exp(32'h7FC00000, 1'b1, {32'h00000000, 3'b010});
        send_exp(32'h00000001, 1'b1, {32'h00000000, 3'b001});
        send_exp(32'h80000000, 1'b1, {32'h00000000, 3'b000});
        drain();

        // stream of 8 with the consumer stalled for cycles 4-6
        lat_chk = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(rand_float(), 1'($urandom_range(0, 1)));
            end
            begin
                repeat (4) begin @(posedge clk); #1; end
                bus.out_ready = 1'b0;
                repeat (3) begin @(posedge clk); #1; end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // randomized traffic with random gaps and backpressure
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send(rand_float(), 1'($urandom_range(0, 1)));
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // reset with three items in flight
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(rand_float(), 1'b1);
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_outputs", 64'(obs), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        lat_chk = 1'b1;
        send_exp(32'h3F800000, 1'b1, {32'h04000000, 3'b000});
        drain();

        // double precision instance
        send_d(64'h3FF0000000000000, {32'h04000000, 3'b000});
        send_d(64'hBFF0000000000000, {32'hFC000000, 3'b000});
        send_d(64'h3FF8000000000000, {32'h06000000, 3'b000});
        send_d(64'h7FF8000000000000, {32'h00000000, 3'b010});

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
